// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/DIVISOR window, TX FIFO and 8N1 shifter.
// Build option: define UART_PARITY_EN to insert an even-parity bit before STOP.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        io_sel,
  output logic [31:0] io_rdata,
  output logic        tx,
  output logic        irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_COUNT  = CW'(1);
`ifdef UART_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;
`else
  localparam logic PARITY_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          state_r;
  logic [7:0]      shift_r;
  logic [15:0]     bit_div_r;
  logic [15:0]     cnt_r;
  logic [2:0]      bit_idx_r;
  logic            tx_r;
  logic            busy_r;
  logic            ovf_r;
  logic [15:0]     divisor_r;
  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_next_s;
  logic            io_sel_s, wr_s, wr_data_s, wr_status_s, wr_div_s;
  logic            full_s, empty_s, bit_end_s, pop_s, push_s, drop_s;
  logic [7:0]      head_s;
  logic [31:0]     io_rdata_s;
  logic            unused_s;

`ifdef UART_PARITY_EN
  logic            par_r;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  assign unused_s    = ^{dataadr[1:0], writedata[31:16]};
  assign io_sel_s    = (dataadr[31:4] == BASE_ADDR[31:4]);
  assign wr_s        = memwrite && io_sel_s;
  assign wr_data_s   = wr_s && (dataadr[3:2] == 2'd0);
  assign wr_status_s = wr_s && (dataadr[3:2] == 2'd1);
  assign wr_div_s    = wr_s && (dataadr[3:2] == 2'd2);
  assign full_s      = (count_r == FULL_COUNT);
  assign empty_s     = (count_r == {CW{1'b0}});
  assign bit_end_s   = (cnt_r == bit_div_r);
  // A pop frees a slot in the same edge, so a push to a full FIFO is still taken then.
  assign pop_s       = !empty_s && ((state_r == S_IDLE) || ((state_r == S_STOP) && bit_end_s));
  assign push_s      = wr_data_s && (!full_s || pop_s);
  assign drop_s      = wr_data_s && full_s && !pop_s;
  assign head_s      = mem_r[rd_ptr_r];

  // FIFO occupancy for the next cycle
  always_comb begin
    count_next_s = count_r;
    if (push_s && !pop_s) begin
      count_next_s = count_r + ONE_COUNT;
    end else if (pop_s && !push_s) begin
      count_next_s = count_r - ONE_COUNT;
    end else begin
      count_next_s = count_r;
    end
  end

  // Register read mux
  always_comb begin
    io_rdata_s = 32'h0000_0000;
    if (io_sel_s) begin
      case (dataadr[3:2])
        2'd1:    io_rdata_s = {25'd0, PARITY_FLAG, busy_r, ovf_r, empty_s, full_s, 2'b00};
        2'd2:    io_rdata_s = {16'h0000, divisor_r};
        default: io_rdata_s = 32'h0000_0000;
      endcase
    end else begin
      io_rdata_s = 32'h0000_0000;
    end
  end

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= writedata[7:0];
    end
  end

  // FIFO pointers, count and control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      count_r   <= {CW{1'b0}};
      ovf_r     <= 1'b0;
      divisor_r <= DIV_RESET;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_next_s;
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (wr_status_s && writedata[4]) begin
        ovf_r <= 1'b0;
      end
      if (wr_div_s) divisor_r <= writedata[15:0];
    end
  end

  // Shifter FSM; tx and busy change on the same edge as the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      shift_r   <= 8'h00;
      bit_div_r <= 16'h0000;
      cnt_r     <= 16'h0000;
      bit_idx_r <= 3'd0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
`ifdef UART_PARITY_EN
      par_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
            state_r   <= S_START;
            shift_r   <= head_s;
            bit_div_r <= divisor_r;
            cnt_r     <= 16'h0000;
            tx_r      <= 1'b0;
            busy_r    <= 1'b1;
`ifdef UART_PARITY_EN
            par_r     <= even_parity(head_s);
`endif
          end
        end
        S_START: begin
          if (bit_end_s) begin
            state_r   <= S_DATA;
            cnt_r     <= 16'h0000;
            bit_idx_r <= 3'd0;
            tx_r      <= shift_r[0];
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end_s) begin
            cnt_r <= 16'h0000;
            if (bit_idx_r == 3'd7) begin
`ifdef UART_PARITY_EN
              state_r <= S_PARITY;
              tx_r    <= par_r;
`else
              state_r <= S_STOP;
              tx_r    <= 1'b1;
`endif
            end else begin
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        S_PARITY: begin
`ifdef UART_PARITY_EN
          if (bit_end_s) begin
            state_r <= S_STOP;
            cnt_r   <= 16'h0000;
            tx_r    <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
`else
          state_r <= S_IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
`endif
        end
        S_STOP: begin
          if (bit_end_s) begin
            cnt_r <= 16'h0000;
            if (pop_s) begin
              state_r   <= S_START;
              shift_r   <= head_s;
              bit_div_r <= divisor_r;
              tx_r      <= 1'b0;
`ifdef UART_PARITY_EN
              par_r     <= even_parity(head_s);
`endif
            end else begin
              state_r <= S_IDLE;
              tx_r    <= 1'b1;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign io_sel   = io_sel_s;
  assign io_rdata = io_rdata_s;
  assign tx       = tx_r;
  assign irq      = (empty_s && !busy_r) || ovf_r;

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the single-cycle CPU's data bus, in parallel with data memory. Decodes the CPU data address, accepts byte writes into a TX FIFO and serialises them as 8N1 frames on a tx pin. Reads are combinational so a load completes in the same cycle, matching data-memory timing. The top level muxes io_rdata onto readdata and suppresses the dmem write when io_sel is high.

Parameters:
BASE_ADDR, 32'hFFFF_FF00, word-aligned base of the 16-byte register window
FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64
DIV_RESET, 16'd433, reset value of DIVISOR (clocks per bit minus 1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
memwrite  input  1  CPU store strobe
dataadr  input  32  CPU data address
writedata  input  32  CPU store data
io_sel  output  1  dataadr[31:4] == BASE_ADDR[31:4]; combinational
io_rdata  output  32  register read data; combinational
tx  output  1  serial output, idle high
irq  output  1  level interrupt: FIFO empty and shifter idle, or overflow set

Behaviour:
- Register map (offset = dataadr[3:2]); unused offsets read 0, writes ignored:
  - 0 TXDATA: write pushes writedata[7:0]; reads 0.
  - 1 STATUS: read {26'b0, busy, ovf, empty, full, 2'b0}, i.e. bit2 full, bit3 empty, bit4 ovf, bit5 busy. Writing 1 to bit4 clears ovf.
  - 2 DIVISOR: R/W, 16 bits in [15:0]; upper bits read 0.
- A write occurs on the rising clk edge when memwrite && io_sel.
- Reset (async assert; effective from the next edge after deassert): FIFO empty, ovf=0, busy=0, DIVISOR=DIV_RESET, tx=1, irq=1 (empty and idle), io_rdata follows decode.
- FIFO: count 0..FIFO_DEPTH; full when count==FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
  - A push when full drops the byte and sets ovf (sticky). Count is unchanged.
  - A push and a pop in the same cycle while full: the pop wins first, so the push is accepted and ovf is not set.
  - A push and a pop in the same cycle while empty is impossible, because pops only occur when count>0.
- Shifter FSM: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count>0, pop the head into the shift register, latch DIVISOR into bit_div, enter START next cycle, busy=1. The pop happens in the cycle IDLE sees count>0.
  - START: tx=0 for bit_div+1 clocks, then DATA.
  - DATA: tx=shift[0], LSB first, for 8 bits of bit_div+1 clocks each; then STOP.
  - STOP: tx=1 for bit_div+1 clocks. Then, if count>0, pop and go directly to START (back-to-back frames, no idle gap); else IDLE with busy=0.
- Frame length is 10*(DIVISOR+1) clocks. tx is registered.
- A DIVISOR write mid-frame takes effect at the next frame. DIVISOR=0 gives a 1-clock bit time.
- busy=1 from the pop cycle until the end of the last STOP bit.
- Reset mid-frame: tx returns to 1 immediately (asynchronous); the frame and FIFO contents are discarded.

Optional Feature:
UART_PARITY_EN:
- Defined: a PARITY state sits between DATA and STOP and transmits even parity (XOR of the 8 data bits) for one bit time. Frame length is 11*(DIVISOR+1). STATUS bit6 reads 1 (parity present).
- Undefined: no PARITY state, 8N1 frames, STATUS bit6 reads 0.

Test Plan:
- Reset, then read STATUS at BASE+4 -> 32'h0000_0008 (empty). tx=1, irq=1. Read DIVISOR -> 433.
- Write DIVISOR=3, then TXDATA=8'h55 -> tx low 4 clocks, then bits 1,0,1,0,1,0,1,0 at 4 clocks each, then high 4 clocks. Total 40 clocks from START entry; busy=1 throughout, irq=0.
- Write 3 bytes back-to-back (A5, 0F, FF) with DIVISOR=0 -> three contiguous 10-clock frames with no idle gap; empty=1 after the third pop; busy falls 30 clocks after the first START.
- With DIVISOR=1000 (slow), write 10 bytes -> the first is popped, then 8 fill the FIFO (full=1), the 10th is dropped with ovf=1 and irq=1. Writing STATUS=32'h10 clears ovf; the 9 accepted bytes are transmitted in order.
- Write DIVISOR=2 mid-frame while at DIVISOR=5 -> the current frame keeps 6-clock bits; the next frame uses 3-clock bits.
- Assert reset mid-DATA -> tx=1 in the same cycle, FIFO empty, ovf=0. A store to an address outside the window (dataadr=32'h0000_0040) -> io_sel=0, no FIFO change.
